// File: rtl/pbus_arbiter.sv
// Two-master round-robin arbiter for the 0x7F00-0x7FFF peripheral window.
// One access at a time: IDLE -> ACCESS (WAIT_CYCLES) -> RESP, or IDLE -> RESP for an out-of-window address.
module pbus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [23:0] WIN_BASE    = 24'h00007F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        err,
  output logic [31:0] pbus_addr,
  output logic [31:0] pbus_wdata,
  output logic        pbus_we,
  input  logic [31:0] pbus_rdata,
  output logic        busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [1:0]  state;
  logic        last_grant;
  logic        grant;
  logic        err_flag;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rdata_lat;

  logic        any_req;
  logic        pick;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_legal;

  assign any_req = m0_req | m1_req;

  // On a tie the master that did not win last time gets the bus.
  always_comb begin
    pick = last_grant;
    if (m0_req && m1_req) pick = ~last_grant;
    else if (m0_req)      pick = 1'b0;
    else if (m1_req)      pick = 1'b1;
  end

  assign sel_we    = pick ? m1_we    : m0_we;
  assign sel_addr  = pick ? m1_addr  : m0_addr;
  assign sel_wdata = pick ? m1_wdata : m0_wdata;
  assign sel_legal = (sel_addr[31:8] == WIN_BASE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      err_flag   <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= pick;
            last_grant <= pick;
            err_flag   <= ~sel_legal;
            cnt        <= CNT_INIT;
            state      <= sel_legal ? ACCESS : RESP;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: datapath latches carry no reset; every output they feed is gated by state, which is reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && any_req) begin
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
      lat_we    <= sel_we;
      rdata_lat <= '0;
    end else if (state == ACCESS && cnt == 4'd0) begin
      rdata_lat <= lat_we ? 32'd0 : pbus_rdata;
    end
  end

  logic in_access;
  logic in_resp;

  assign in_access = (state == ACCESS);
  assign in_resp   = (state == RESP);

  assign pbus_addr  = in_access ? lat_addr  : 32'd0;
  assign pbus_wdata = in_access ? lat_wdata : 32'd0;
  // The count only falls, so its initial value marks the first ACCESS cycle: exactly one strobe per write.
  assign pbus_we    = in_access && lat_we && (cnt == CNT_INIT) && !reset;

  assign m0_ack   = in_resp && !grant;
  assign m1_ack   = in_resp &&  grant;
  assign m0_rdata = m0_ack ? rdata_lat : 32'd0;
  assign m1_rdata = m1_ack ? rdata_lat : 32'd0;
  assign err      = in_resp && err_flag;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_pbus_arbiter.sv
// Random two-master traffic on two arbiters (WAIT_CYCLES 1 and 3) checked every cycle
// against a transaction-timeline model: grant cycle, strobe cycle, sample cycle, ack cycle.
module tb_pbus_arbiter;

  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        req   [2][2];
  logic        we    [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic        ack   [2][2];
  logic [31:0] rdata [2][2];
  logic        err   [2];
  logic [31:0] pa    [2];
  logic [31:0] pw    [2];
  logic        pwe   [2];
  logic [31:0] prd   [2];
  logic        busy  [2];

  pbus_arbiter #(.WAIT_CYCLES(1), .WIN_BASE(24'h00007F)) dut_w1 (
    .clk(clk), .reset(rst[0]),
    .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
    .m0_ack(ack[0][0]), .m0_rdata(rdata[0][0]),
    .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
    .m1_ack(ack[0][1]), .m1_rdata(rdata[0][1]),
    .err(err[0]), .pbus_addr(pa[0]), .pbus_wdata(pw[0]), .pbus_we(pwe[0]),
    .pbus_rdata(prd[0]), .busy(busy[0])
  );

  pbus_arbiter #(.WAIT_CYCLES(3), .WIN_BASE(24'h00007F)) dut_w3 (
    .clk(clk), .reset(rst[1]),
    .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
    .m0_ack(ack[1][0]), .m0_rdata(rdata[1][0]),
    .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
    .m1_ack(ack[1][1]), .m1_rdata(rdata[1][1]),
    .err(err[1]), .pbus_addr(pa[1]), .pbus_wdata(pw[1]), .pbus_we(pwe[1]),
    .pbus_rdata(prd[1]), .busy(busy[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int wc [2];

  // Reference timeline per instance: one outstanding access, described by its cycle numbers.
  bit          act   [2];
  bit          lastg [2];
  bit          g     [2];
  bit          legal [2];
  bit          mwe   [2];
  int          t0    [2];
  int          ack_c [2];
  logic [31:0] maddr [2];
  logic [31:0] mwd   [2];
  logic [31:0] mrd   [2];
  bit          exp_ack [2][2];
  int          n_acks  [2];
  int          n_resets[2];

  // Master stimulus: a pending request is held until its ack.
  bit          pend [2][2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, want %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input int k);
    logic [31:0] e_pa, e_pw;
    logic [31:0] e_rd [2];
    bit          e_pwe, e_busy, e_err;
    bit          e_ack [2];
    string       p;
    e_pa = '0; e_pw = '0; e_pwe = 0; e_busy = 0; e_err = 0;
    e_rd[0] = '0; e_rd[1] = '0; e_ack[0] = 0; e_ack[1] = 0;
    if (act[k] && cyc > t0[k]) begin
      e_busy = 1;
      if (cyc == ack_c[k]) begin
        e_ack[g[k]] = 1;
        e_rd[g[k]]  = mrd[k];
        e_err       = !legal[k];
      end else begin
        e_pa  = maddr[k];
        e_pw  = mwd[k];
        e_pwe = (cyc == t0[k] + 1) && mwe[k] && !rst[k];
        if (cyc == t0[k] + wc[k]) mrd[k] = mwe[k] ? 32'd0 : prd[k];
      end
    end
    exp_ack[k][0] = e_ack[0];
    exp_ack[k][1] = e_ack[1];
    if (e_ack[0] || e_ack[1]) n_acks[k]++;

    if (cyc >= 1) begin
      p = $sformatf("w%0d ", wc[k]);
      check({p, "m0_ack"},     32'(ack[k][0]), 32'(e_ack[0]));
      check({p, "m1_ack"},     32'(ack[k][1]), 32'(e_ack[1]));
      check({p, "m0_rdata"},   rdata[k][0],    e_rd[0]);
      check({p, "m1_rdata"},   rdata[k][1],    e_rd[1]);
      check({p, "err"},        32'(err[k]),    32'(e_err));
      check({p, "pbus_addr"},  pa[k],          e_pa);
      check({p, "pbus_wdata"}, pw[k],          e_pw);
      check({p, "pbus_we"},    32'(pwe[k]),    32'(e_pwe));
      check({p, "busy"},       32'(busy[k]),   32'(e_busy));
    end

    if (rst[k]) begin
      act[k]   = 0;
      lastg[k] = 1;
    end else if (act[k] && cyc == ack_c[k]) begin
      act[k] = 0;
    end else if (!act[k] && (req[k][0] || req[k][1])) begin
      if (req[k][0] && req[k][1]) g[k] = !lastg[k];
      else                        g[k] = req[k][1];
      lastg[k] = g[k];
      act[k]   = 1;
      t0[k]    = cyc;
      maddr[k] = addr[k][g[k]];
      mwd[k]   = wdata[k][g[k]];
      mwe[k]   = we[k][g[k]];
      legal[k] = (maddr[k][31:8] == 24'h00007F);
      mrd[k]   = '0;
      ack_c[k] = legal[k] ? cyc + wc[k] + 1 : cyc + 1;
    end
  endtask

  task automatic drive();
    logic [31:0] a;
    for (int k = 0; k < 2; k++) begin
      for (int m = 0; m < 2; m++) begin
        if (exp_ack[k][m]) pend[k][m] = 0;
        if (!pend[k][m] && $urandom_range(0, 99) < 65) begin
          pend[k][m] = 1;
          we[k][m]   = 1'($urandom_range(0, 1));
          wdata[k][m] = $urandom;
          a = $urandom;
          if ($urandom_range(0, 99) < 80) a = {24'h00007F, a[7:0]};
          else if (a[31:8] == 24'h00007F) a[31] = 1'b1;
          addr[k][m] = a;
        end else if (!pend[k][m]) begin
          we[k][m]    = 1'($urandom_range(0, 1));
          addr[k][m]  = $urandom;
          wdata[k][m] = $urandom;
        end
        req[k][m] = pend[k][m];
      end
      prd[k] = $urandom;
      if (cyc < 3) rst[k] = 1'b1;
      else rst[k] = act[k] && legal[k] && cyc > t0[k] && cyc < ack_c[k]
                    && ($urandom_range(0, 29) == 0);
      if (rst[k]) n_resets[k]++;
    end
  endtask

  initial begin
    wc[0] = 1;
    wc[1] = 3;
    for (int k = 0; k < 2; k++) begin
      act[k] = 0; lastg[k] = 1; n_acks[k] = 0; n_resets[k] = 0;
      for (int m = 0; m < 2; m++) begin
        pend[k][m] = 0; exp_ack[k][m] = 0;
      end
    end
    drive();
    repeat (NCYC) begin
      @(negedge clk);
      step(0);
      step(1);
      @(posedge clk);
      cyc++;
      #1;
      drive();
    end
    for (int k = 0; k < 2; k++)
      check($sformatf("w%0d traffic_seen", wc[k]), 32'(n_acks[k] > 50), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
